// File: rtl/moore_pkg.sv
// Shared helpers for the Moore sequence detector: state width and the
// elaboration-time prefix-fallback rule used to build the next-state table.
package moore_pkg;

    function automatic int state_width(input int len);
        return $clog2(len + 1);
    endfunction

    // Longest prefix of the pattern that is a suffix of (matched history + new bit).
    // Pattern is right-aligned in 16 bits, pattern[len-1] being the first bit on the wire.
    function automatic int next_match(
        input int          s,
        input logic        data_bit,
        input logic [15:0] pattern,
        input int          len,
        input logic        overlap
    );
        logic [16:0] seq;
        int          hist_len;
        int          n;
        logic        ok;
        int          result;
        seq      = '0;
        result   = 0;
        hist_len = (s == len && !overlap) ? 0 : s;
        n        = hist_len + 1;
        for (int i = 0; i < 16; i++) begin
            if (i < hist_len) begin
                seq[i] = pattern[len - 1 - i];
            end
        end
        seq[hist_len] = data_bit;
        for (int k = 1; k <= 16; k++) begin
            if (k <= len && k <= n) begin
                ok = 1'b1;
                for (int j = 0; j < 16; j++) begin
                    if (j < k && seq[n - k + j] != pattern[len - 1 - j]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    result = k;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/moore_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
module moore_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != {CNT_W{1'b1}}) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/moore_seq_detect.sv
// Parametrised Moore serial sequence detector with prefix fallback, state-only
// detect output and a saturating hit counter.
module moore_seq_detect
    import moore_pkg::*;
#(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter logic                   OVERLAP     = 1'b1,
    parameter int                     CNT_W       = 8,
    localparam int                    SW          = state_width(PATTERN_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             clear,
    output logic             detected,
    output logic [CNT_W-1:0] hit_count,
    output logic [SW-1:0]    estados
);

    localparam int          TAB_N   = 2 ** (SW + 1);
    localparam logic [15:0] PAT_EXT = 16'(PATTERN);
    localparam logic [SW-1:0] FOUND = SW'(PATTERN_LEN);

    logic [SW-1:0] state;
    logic [SW-1:0] next_state;
    logic          hit;
    logic [SW-1:0] next_tab [TAB_N];

    // Table indexed by {state, data_in}; unreachable state codes fall back to 0.
    for (genvar gi = 0; gi < TAB_N; gi++) begin : g_tab
        localparam int GS = gi / 2;
        if (GS > PATTERN_LEN) begin : g_unused
            assign next_tab[gi] = '0;
        end else begin : g_used
            localparam logic [SW-1:0] NXT =
                SW'(next_match(GS, 1'(gi % 2), PAT_EXT, PATTERN_LEN, OVERLAP));
            assign next_tab[gi] = NXT;
        end
    end

    assign next_state = next_tab[{state, data_in}];
    assign hit        = data_valid && !clear && (next_state == FOUND);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= '0;
        end else if (clear) begin
            state <= '0;
        end else if (data_valid) begin
            state <= next_state;
        end
    end

    assign detected = (state == FOUND);
    assign estados  = state;

    moore_sat_counter #(
        .CNT_W (CNT_W)
    ) u_hit_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clr   (clear),
        .count (hit_count)
    );

endmodule
